// File: rtl/led_pwm_if.sv
// Avalon-MM register port of the LED PWM driver: a master drives the
// address/strobe/data signals and the slave returns zero-wait-state readdata.
interface led_pwm_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/led_pwm_driver.sv
// Drives the 8 board LEDs from the PIO pattern, adding global PWM brightness,
// optional blinking and polarity inversion, configured over an Avalon-MM slave.
module led_pwm_driver #(
  parameter int unsigned PWM_DIV = 1,
  parameter int unsigned BLINK_W = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    pattern_in,
  led_pwm_if.slave      bus,
  output logic [7:0]    led
);

  typedef struct packed {
    logic invert;
    logic blink_en;
    logic enable;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{invert: 1'b0, blink_en: 1'b0, enable: 1'b1};
  localparam int unsigned PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

  ctrl_t              ctrl_q, ctrl_d;
  logic [7:0]         duty_q, duty_d;
  logic [7:0]         duty_act_q, duty_act_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [7:0]         pwm_cnt_q, pwm_cnt_d;
  logic [7:0]         pattern_q, pattern_d;
  logic [7:0]         led_q, led_d;

  logic wr, ctrl_we, duty_we, blink_we;
  logic tick, period_start, pwm_on, blink_on;
  logic [7:0] raw;
  logic unused_wdata;

  assign wr       = bus.chipselect & ~bus.write_n;
  assign ctrl_we  = wr && (bus.address == 2'd0);
  assign duty_we  = wr && (bus.address == 2'd1);
  assign blink_we = wr && (bus.address == 2'd2);
  assign unused_wdata = ^bus.writedata;

  assign tick         = (pre_cnt_q == PRE_LAST);
  assign period_start = tick && (pwm_cnt_q == 8'd254);
  // pwm_cnt never reaches 255, so duty 255 keeps the LEDs on for the whole period.
  assign pwm_on       = (pwm_cnt_q < duty_act_q);
  assign blink_on     = ctrl_q.blink_en && (blink_q != '0);
  assign raw          = pattern_q & {8{ctrl_q.enable & pwm_on & phase_q}};

  // NOTE: every *_d gets its hold value first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    ctrl_d      = ctrl_q;
    duty_d      = duty_q;
    duty_act_d  = duty_act_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    pwm_cnt_d   = pwm_cnt_q;
    pattern_d   = pattern_in;
    led_d       = ctrl_q.invert ? ~raw : raw;
    pre_cnt_d   = tick ? '0 : pre_cnt_q + 1'b1;

    if (tick) pwm_cnt_d = (pwm_cnt_q == 8'd254) ? 8'd0 : pwm_cnt_q + 8'd1;

    if (ctrl_we)  ctrl_d  = ctrl_t'(bus.writedata[2:0]);
    if (duty_we)  duty_d  = bus.writedata[7:0];
    if (blink_we) blink_d = bus.writedata[BLINK_W-1:0];

    // Brightness only changes on a period boundary; a write landing on that
    // same cycle is taken directly.
    if (period_start) duty_act_d = duty_we ? bus.writedata[7:0] : duty_q;

    if (blink_we || !blink_on) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (period_start) begin
      if (blink_cnt_q == blink_q - 1'b1) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q      <= CTRL_RST;
      duty_q      <= 8'hFF;
      duty_act_q  <= 8'hFF;
      blink_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      pre_cnt_q   <= '0;
      pwm_cnt_q   <= 8'd0;
      pattern_q   <= 8'h00;
      led_q       <= 8'h00;
    end else begin
      ctrl_q      <= ctrl_d;
      duty_q      <= duty_d;
      duty_act_q  <= duty_act_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pre_cnt_q   <= pre_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      pattern_q   <= pattern_d;
      led_q       <= led_d;
    end
  end

  assign led = led_q;

  always_comb begin
    bus.readdata = 32'h0;
    case (bus.address)
      2'd0:    bus.readdata = 32'(ctrl_q);
      2'd1:    bus.readdata = 32'(duty_q);
      2'd2:    bus.readdata = 32'(blink_q);
      default: bus.readdata = {23'h0, phase_q, pattern_q};
    endcase
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: an arithmetic model of the LED output and register
// file checked every cycle, plus directed scenarios with hand-computed values.
module tb_led_pwm_driver;
  localparam int DIV    = 1;
  localparam int PERIOD = 255 * DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pattern_in = 8'hA5;
  logic [7:0] led;

  led_pwm_if bus_if ();

  led_pwm_driver #(.PWM_DIV(DIV), .BLINK_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pattern_in (pattern_in),
    .bus        (bus_if),
    .led        (led)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: time is the number of clock edges since reset, PWM position
  // is derived from it arithmetically, blink phase from period starts counted.
  int unsigned m_t       = 0;
  int unsigned m_nstarts = 0;
  logic [2:0]  m_ctrl    = 3'b001;
  logic [7:0]  m_duty    = 8'hFF;
  logic [7:0]  m_duty_act = 8'hFF;
  logic [15:0] m_blink   = 16'h0;
  logic        m_phase   = 1'b1;
  logic [7:0]  m_pat_q   = 8'h00;
  logic [7:0]  m_led     = 8'h00;
  bit          s_wr, s_ps, s_on, s_act;
  logic [7:0]  s_raw;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {29'h0, m_ctrl};
      2'd1:    return {24'h0, m_duty};
      2'd2:    return {16'h0, m_blink};
      default: return {23'h0, m_phase, m_pat_q};
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_t = 0; m_nstarts = 0; m_ctrl = 3'b001; m_duty = 8'hFF; m_duty_act = 8'hFF;
      m_blink = 16'h0; m_phase = 1'b1; m_pat_q = 8'h00; m_led = 8'h00;
    end else begin
      s_ps  = ((m_t + 1) % PERIOD) == 0;
      s_on  = ((m_t / DIV) % 255) < m_duty_act;
      s_raw = (m_ctrl[0] && s_on && m_phase) ? m_pat_q : 8'h00;
      m_led = m_ctrl[2] ? ~s_raw : s_raw;
      s_wr  = bus_if.chipselect && !bus_if.write_n;
      s_act = m_ctrl[1] && (m_blink != 0);
      if (s_ps) m_duty_act = (s_wr && bus_if.address == 2'd1) ? bus_if.writedata[7:0] : m_duty;
      if ((s_wr && bus_if.address == 2'd2) || !s_act) begin
        m_nstarts = 0;
        m_phase   = 1'b1;
      end else begin
        if (s_ps) m_nstarts++;
        m_phase = ((m_nstarts / m_blink) % 2) == 0;
      end
      if (s_wr) begin
        case (bus_if.address)
          2'd0: m_ctrl  = bus_if.writedata[2:0];
          2'd1: m_duty  = bus_if.writedata[7:0];
          2'd2: m_blink = bus_if.writedata[15:0];
          default: ;
        endcase
      end
      m_pat_q = pattern_in;
      m_t++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (reset_n) begin
      check("model_led", {24'h0, led}, {24'h0, m_led});
      check("model_readdata", bus_if.readdata, m_read(bus_if.address));
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.address = a; bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0; bus_if.writedata = d;
    @(negedge clk);
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus_if.address = a;
    #1;
    check(name, bus_if.readdata, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_led(input int n, input logic [7:0] val, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (led === val) cnt++;
    end
  endtask

  task automatic run_length(input logic [7:0] val, output int run);
    run = 1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (led !== val) break;
      run++;
    end
  endtask

  initial begin
    int cnt;
    int run;
    bit found;
    bus_if.address = 2'd0; bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1; bus_if.writedata = 32'h0;

    // Reset values and pattern latency
    wait_cycles(3);
    check("reset_led", {24'h0, led}, 32'h00);
    read_check("reset_ctrl", 2'd0, 32'h1);
    read_check("reset_duty", 2'd1, 32'hFF);
    read_check("reset_blink", 2'd2, 32'h0);
    read_check("reset_status", 2'd3, 32'h100);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("latency_1clk", {24'h0, led}, 32'h00);
    @(negedge clk);
    check("latency_2clk", {24'h0, led}, 32'hA5);
    read_check("read_duty", 2'd1, 32'hFF);
    read_check("read_ctrl", 2'd0, 32'h1);
    read_check("read_status", 2'd3, 32'h1A5);

    // Duty 64: readback is immediate, brightness waits for the next period
    bus_write(2'd1, 32'd64);
    read_check("duty_readback", 2'd1, 32'd64);
    wait_cycles(90);
    count_led(100, 8'hA5, cnt);
    check("duty_old_until_period", cnt, 100);
    wait_cycles(2 * PERIOD);
    for (int p = 0; p < 3; p++) begin
      count_led(PERIOD, 8'hA5, cnt);
      check("duty64_on_count", cnt, 64);
    end

    // Duty extremes
    bus_write(2'd1, 32'd0);
    wait_cycles(2 * PERIOD);
    count_led(PERIOD, 8'h00, cnt);
    check("duty0_off", cnt, PERIOD);
    bus_write(2'd1, 32'd255);
    wait_cycles(2 * PERIOD);
    count_led(PERIOD, 8'hA5, cnt);
    check("duty255_on", cnt, PERIOD);

    // Blink with half-period of 2 PWM periods
    pattern_in = 8'hFF;
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'h3);
    found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (led === 8'h00) begin found = 1'b1; break; end
    end
    check("blink_off_seen", {31'h0, found}, 32'h1);
    run_length(8'h00, run);
    check("blink_off_len", run, 510);
    run_length(8'hFF, run);
    check("blink_on_len", run, 510);
    wait_cycles(100);
    read_check("blink_status_off", 2'd3, 32'h0FF);
    bus_write(2'd2, 32'd2);
    read_check("blink_rewrite_phase", 2'd3, 32'h1FF);
    check("blink_rewrite_led_pre", {24'h0, led}, 32'h00);
    @(negedge clk);
    check("blink_rewrite_led", {24'h0, led}, 32'hFF);

    // Inversion
    pattern_in = 8'h0F;
    bus_write(2'd0, 32'h5);
    wait_cycles(3);
    check("invert_on", {24'h0, led}, 32'hF0);
    bus_write(2'd0, 32'h4);
    wait_cycles(2);
    check("invert_disabled", {24'h0, led}, 32'hFF);

    // Asynchronous reset while blinking
    bus_write(2'd1, 32'd128);
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'h3);
    wait_cycles(300);
    found = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (led !== 8'h00) begin found = 1'b1; break; end
    end
    check("pre_reset_led_on", {31'h0, found}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_led", {24'h0, led}, 32'h00);
    read_check("rst_ctrl", 2'd0, 32'h1);
    read_check("rst_duty", 2'd1, 32'hFF);
    read_check("rst_blink", 2'd2, 32'h0);
    read_check("rst_status", 2'd3, 32'h100);
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
